door_cmd_ctrl: RTL and testbench



---
 rtl/door_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/door_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_door_cmd_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/door_pkg.sv
// Shared constants and state encoding for the servo door command path.
// Default cycle counts are derived from the 100 MHz clock and the servo frame timing.
package door_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } door_state_t;

  localparam int CLK_HZ       = 100_000_000;
  localparam int FRAME_CYCLES = 1_000_000;
  localparam int STEP         = 500;
  localparam int STEPS        = 200;

  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 50;
  localparam int SWEEP_CYCLES_DEF    = FRAME_CYCLES * STEPS;
  localparam int HOLD_CYCLES_DEF     = 5 * CLK_HZ;
  localparam int TW_DEF              = 29;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and rising-edge pulse.
// The pulse is high for the single cycle after the debounced level rises.
module btn_debounce
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  // A synchronised value that returns to the current level before the count
  // completes clears the counter, so only an uninterrupted run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/door_cmd_ctrl.sv
// Door sequencer: debounced buttons drive a CLOSED/OPENING/OPEN/CLOSING FSM whose
// timer sets how long the open/close sweep levels are held for the servo stage.
module door_cmd_ctrl
  import door_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SWEEP_CYCLES    = SWEEP_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int TW              = TW_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_btn_open_raw,
  input  logic       i_btn_close_raw,
  output logic       o_open_cmd,
  output logic       o_close_cmd,
  output logic       o_door_open,
  output logic       o_busy,
  output logic [1:0] o_state
);

  localparam logic [TW-1:0] SWEEP = TW'(SWEEP_CYCLES);
  localparam logic [TW-1:0] HOLD  = TW'(HOLD_CYCLES);
  localparam logic [TW-1:0] ONE   = TW'(1);

  logic w_open_press;
  logic w_close_press;
  logic w_open_level;
  logic w_close_level;
  logic w_levels_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_open_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (i_btn_open_raw),
    .o_level (w_open_level),
    .o_press (w_open_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_close_btn (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (i_btn_close_raw),
    .o_level (w_close_level),
    .o_press (w_close_press)
  );

  assign w_levels_unused = w_open_level | w_close_level;

  door_state_t   r_state;
  door_state_t   w_next;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_next;
  logic [TW-1:0] w_elapsed;
  logic          w_expire;
  logic          r_open_cmd;
  logic          r_close_cmd;
  logic          r_door_open;
  logic          r_busy;

  // Reversing mid-sweep reloads the travel already covered, returning the door to its start.
  assign w_elapsed = SWEEP - r_timer;
  assign w_expire  = (r_timer == ONE);

  always_comb begin
    w_next       = r_state;
    w_timer_next = r_timer;
    case (r_state)
      CLOSED: begin
        if (w_open_press) begin
          w_next       = OPENING;
          w_timer_next = SWEEP;
        end
      end
      OPENING: begin
        if (w_close_press && !w_open_press) begin
          if (w_elapsed == '0) begin
            w_next       = CLOSED;
            w_timer_next = '0;
          end else begin
            w_next       = CLOSING;
            w_timer_next = w_elapsed;
          end
        end else if (w_expire) begin
          w_next       = OPEN;
          w_timer_next = HOLD;
        end else begin
          w_timer_next = r_timer - ONE;
        end
      end
      OPEN: begin
        if (w_open_press) begin
          w_timer_next = HOLD;
        end else if (w_close_press || w_expire) begin
          w_next       = CLOSING;
          w_timer_next = SWEEP;
        end else begin
          w_timer_next = r_timer - ONE;
        end
      end
      CLOSING: begin
        if (w_open_press) begin
          if (w_elapsed == '0) begin
            w_next       = OPEN;
            w_timer_next = HOLD;
          end else begin
            w_next       = OPENING;
            w_timer_next = w_elapsed;
          end
        end else if (w_expire) begin
          w_next       = CLOSED;
          w_timer_next = '0;
        end else begin
          w_timer_next = r_timer - ONE;
        end
      end
      default: begin
        w_next       = CLOSED;
        w_timer_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the command swap happens on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CLOSED;
      r_timer     <= '0;
      r_open_cmd  <= 1'b0;
      r_close_cmd <= 1'b0;
      r_door_open <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_timer     <= w_timer_next;
      r_open_cmd  <= (w_next == OPENING);
      r_close_cmd <= (w_next == CLOSING);
      r_door_open <= (w_next == OPEN);
      r_busy      <= (w_next == OPENING) || (w_next == CLOSING);
    end
  end

  assign o_open_cmd  = r_open_cmd;
  assign o_close_cmd = r_close_cmd;
  assign o_door_open = r_door_open;
  assign o_busy      = r_busy;
  assign o_state     = r_state;

endmodule

// File: tb/tb_door_cmd_ctrl.sv
// Self-checking bench for door_cmd_ctrl: vector table, directed corner sequences,
// and randomized buttons checked against a position-based behavioural door model.
module tb_door_cmd_ctrl;

  localparam int D = 4;
  localparam int S = 10;
  localparam int H = 20;

  logic       clk;
  logic       rst_n;
  logic       btnOpen;
  logic       btnClose;
  logic       openCmd;
  logic       closeCmd;
  logic       doorOpen;
  logic       busy;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  door_cmd_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .SWEEP_CYCLES   (S),
    .HOLD_CYCLES    (H),
    .TW             (29)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_btn_open_raw (btnOpen),
    .i_btn_close_raw(btnClose),
    .o_open_cmd     (openCmd),
    .o_close_cmd    (closeCmd),
    .o_door_open    (doorOpen),
    .o_busy         (busy),
    .o_state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       bo;
    logic       bc;
    int         n;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  // Expected output bundle {state, open_cmd, close_cmd, door_open, busy} for a state code.
  function automatic logic [5:0] expectFor(input logic [1:0] st);
    return {st, st == 2'b01, st == 2'b11, st == 2'b10, st == 2'b01 || st == 2'b11};
  endfunction

  task automatic checkOutput(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {state, openCmd, closeCmd, doorOpen, busy};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic bo, input logic bc, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      btnOpen  = bo;
      btnClose = bc;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    btnOpen  = 1'b0;
    btnClose = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: the door tracks its travelled position; a button press is the
  // debounced level rising once D consecutive synchronised samples disagree with it.
  int mPhase;
  int mPos;
  int mHold;
  bit mLvlO, mLvlC, mRoseO, mRoseC;
  bit qO[$];
  bit qC[$];

  function automatic bit settled(input bit q[$], input bit lvl);
    for (int j = 0; j < D; j++)
      if (q[q.size() - 3 - j] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelReset();
    mPhase = 0; mPos = 0; mHold = 0;
    mLvlO = 0; mLvlC = 0; mRoseO = 0; mRoseC = 0;
    qO.delete(); qC.delete();
    for (int i = 0; i < D + 2; i++) begin
      qO.push_back(1'b0);
      qC.push_back(1'b0);
    end
  endtask

  task automatic modelStep(input bit bo, input bit bc);
    bit pO, pC;
    pO = mRoseO;
    pC = mRoseC;
    case (mPhase)
      0: if (pO) begin mPhase = 1; mPos = 0; end
      1: begin
        if (pC && !pO) mPhase = (mPos == 0) ? 0 : 3;
        else if (mPos == S - 1) begin mPhase = 2; mHold = H; end
        else mPos++;
      end
      2: begin
        if (pO) mHold = H;
        else if (pC || mHold == 1) begin mPhase = 3; mPos = S; end
        else mHold--;
      end
      default: begin
        if (pO) begin
          if (mPos == S) begin mPhase = 2; mHold = H; end
          else mPhase = 1;
        end else if (mPos == 1) mPhase = 0;
        else mPos--;
      end
    endcase
    qO.push_back(bo);
    qC.push_back(bc);
    mRoseO = 0;
    mRoseC = 0;
    if (settled(qO, mLvlO)) begin mLvlO = !mLvlO; mRoseO = mLvlO; end
    if (settled(qC, mLvlC)) begin mLvlC = !mLvlC; mRoseC = mLvlC; end
    void'(qO.pop_front());
    void'(qC.pop_front());
  endtask

  initial begin
    btnOpen  = 1'b0;
    btnClose = 1'b0;
    rst_n    = 1'b0;
    #12;
    checkOutput("reset state", expectFor(2'b00));
    @(negedge clk);
    rst_n = 1'b1;

    // Clean open press held 8 clocks, through the full open/hold/close cycle.
    vecs.push_back('{1'b1, 1'b0, 6,  2'b00});
    vecs.push_back('{1'b1, 1'b0, 1,  2'b01});
    vecs.push_back('{1'b1, 1'b0, 1,  2'b01});
    vecs.push_back('{1'b0, 1'b0, 8,  2'b01});
    vecs.push_back('{1'b0, 1'b0, 1,  2'b10});
    vecs.push_back('{1'b0, 1'b0, 19, 2'b10});
    vecs.push_back('{1'b0, 1'b0, 1,  2'b11});
    vecs.push_back('{1'b0, 1'b0, 9,  2'b11});
    vecs.push_back('{1'b0, 1'b0, 1,  2'b00});
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].bo, vecs[i].bc, vecs[i].n);
      checkOutput($sformatf("vec%0d", i), expectFor(vecs[i].st));
    end

    // Bouncing open line never settles.
    doReset();
    for (int c = 0; c < 30; c++) begin
      applyStimulus((c < 20) && ((c / 2) % 2 == 0), 1'b0, 1);
      checkOutput($sformatf("bounce c%0d", c), expectFor(2'b00));
    end

    // Close press while opening with timer=6 reverses for 4 clocks.
    doReset();
    applyStimulus(1'b1, 1'b0, 5);
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 3);
    checkOutput("reverse before", expectFor(2'b01));
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("reverse start", expectFor(2'b11));
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("reverse last", expectFor(2'b11));
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("reverse closed", expectFor(2'b00));

    // Close press on the first opening cycle: zero travel goes straight to CLOSED.
    doReset();
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 6);
    checkOutput("zero travel opening", expectFor(2'b01));
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("zero travel closed", expectFor(2'b00));
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("zero travel idle", expectFor(2'b00));

    // Both buttons together in CLOSED and in OPEN: open wins each time.
    doReset();
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("both closed", expectFor(2'b01));
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("both reach open", expectFor(2'b10));
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b1, 1'b1, 7);
    checkOutput("both open reload", expectFor(2'b10));
    applyStimulus(1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 18);
    checkOutput("both open held", expectFor(2'b10));
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("both open closing", expectFor(2'b11));

    // Open press in OPEN at timer=3 restarts the full hold.
    doReset();
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 9);
    checkOutput("hold reach open", expectFor(2'b10));
    applyStimulus(1'b0, 1'b0, 11);
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("hold timer3", expectFor(2'b10));
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 18);
    checkOutput("hold extended", expectFor(2'b10));
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("hold closing", expectFor(2'b11));

    // Asynchronous reset mid-opening, then a fresh full sweep.
    doReset();
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("pre reset opening", expectFor(2'b01));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", expectFor(2'b00));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 6);
    checkOutput("fresh idle", expectFor(2'b00));
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput("fresh start", expectFor(2'b01));
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("fresh last", expectFor(2'b01));
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("fresh open", expectFor(2'b10));

    // Randomized button activity against the reference model.
    doReset();
    modelReset();
    for (int seg = 0; seg < 300; seg++) begin
      logic bo, bc;
      int len;
      bo  = 1'($urandom_range(0, 1));
      bc  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 14);
      for (int k = 0; k < len; k++) begin
        applyStimulus(bo, bc, 1);
        modelStep(bo, bc);
        checkOutput($sformatf("rand seg%0d k%0d", seg, k), expectFor(2'(mPhase)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
